// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline hazard/exception controller with run-state FSM and
// saturating performance counters for a five-stage Y86-style pipeline.
//
// Parameters
//   FLUSH_CYCLES : cycles spent bubbling the pipeline after reset
//   CNT_W        : width of each performance counter
//
// Ports
//   clk, rst                     : clock, synchronous active-high reset
//   start                        : pulse, leaves IDLE for RUN (ignored elsewhere)
//   D/E/M/W_icode                : icode held in each pipeline register
//   d_srcA, d_srcB               : decode source registers (4'hF = none)
//   E_dstM                       : execute-stage load destination
//   e_cnd                        : execute-stage condition result
//   m_stat, W_stat               : one-hot stat codes (AOK/HLT/ADR/INS)
//   F_stall .. W_stall           : stage stall/bubble controls
//   state                        : FLUSH=0, IDLE=1, RUN=2, HALTED=3
//   cpu_stat                     : status latched when the pipeline halts
//   cycle_cnt/retire_cnt/stall_cnt : saturating counters, advance only in RUN
//
// There is no input handshake: every control is a combinational function of
// the current state and the stage inputs in the same cycle.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic [1:0]       state,
  output logic [3:0]       cpu_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;
  localparam logic [3:0] REG_NONE = 4'hF;

  localparam int          FW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [FW-1:0]    flush_q, flush_d;
  logic [3:0]       cpu_stat_q, cpu_stat_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic loaduse, retp, mispred, w_exc, m_exc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Hazard terms, only consumed while in RUN.
  always_comb begin
    loaduse = ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_dstM != REG_NONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    retp    = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
    mispred = (E_icode == 4'h7) && !e_cnd;
    m_exc   = (m_stat == STAT_HLT) || (m_stat == STAT_ADR) || (m_stat == STAT_INS);
    w_exc   = (W_stat == STAT_HLT) || (W_stat == STAT_ADR) || (W_stat == STAT_INS);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FLUSH;
      flush_q    <= '0;
      cpu_stat_q <= STAT_AOK;
      cycle_q    <= '0;
      retire_q   <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      cpu_stat_q <= cpu_stat_d;
      cycle_q    <= cycle_d;
      retire_q   <= retire_d;
      stall_q    <= stall_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    flush_d    = '0;
    cpu_stat_d = cpu_stat_q;
    unique case (state_q)
      ST_FLUSH: begin
        if (flush_q == FLUSH_LAST) state_d = ST_IDLE;
        else                       flush_d = flush_q + FW'(1);
      end
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        // Any non-AOK status reaching write-back ends execution.
        if (W_stat != STAT_AOK) begin
          state_d    = ST_HALTED;
          cpu_stat_d = W_stat;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_FLUSH;
    endcase
  end

  // Output logic
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    unique case (state_q)
      ST_FLUSH, ST_IDLE: begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
      end
      ST_RUN: begin
        // Load-use wins over ret in decode: the stalled instruction must stay
        // in D, so it cannot also be bubbled.
        F_stall  = loaduse || retp;
        D_stall  = loaduse;
        D_bubble = mispred || (retp && !loaduse);
        E_bubble = mispred || loaduse;
        M_bubble = m_exc || w_exc;
        W_stall  = (W_stat != STAT_AOK);
      end
      ST_HALTED: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
      end
      default: ;
    endcase
  end

  // Performance counters: advance only for cycles spent in RUN.
  always_comb begin
    cycle_d  = cycle_q;
    retire_d = retire_q;
    stall_d  = stall_q;
    if (state_q == ST_RUN) begin
      cycle_d = sat_inc(cycle_q);
      if ((W_stat == STAT_AOK) && (W_icode != 4'h1)) retire_d = sat_inc(retire_q);
      if (F_stall || D_bubble || E_bubble)           stall_d  = sat_inc(stall_q);
    end
  end

  assign state      = state_q;
  assign cpu_stat   = cpu_stat_q;
  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- directed, table-driven bench for pipe_ctrl. A second
// instance with CNT_W=4 shares every input to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, e_cnd;
  logic [3:0] D_icode, E_icode, M_icode, W_icode, d_srcA, d_srcB, E_dstM, m_stat, W_stat;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
  logic [1:0] state;
  logic [3:0] cpu_stat;
  logic [31:0] cycle_cnt, retire_cnt, stall_cnt;

  logic       s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall;
  logic [1:0] s_state;
  logic [3:0] s_cpu_stat;
  logic [3:0] s_cycle_cnt, s_retire_cnt, s_stall_cnt;

  pipe_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .state(state), .cpu_stat(cpu_stat),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.FLUSH_CYCLES(4), .CNT_W(4)) u_dut_s (
    .clk(clk), .rst(rst), .start(start),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(s_F_stall), .D_stall(s_D_stall), .D_bubble(s_D_bubble), .E_bubble(s_E_bubble),
    .M_bubble(s_M_bubble), .W_stall(s_W_stall), .state(s_state), .cpu_stat(s_cpu_stat),
    .cycle_cnt(s_cycle_cnt), .retire_cnt(s_retire_cnt), .stall_cnt(s_stall_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [1:0] exp_q[$];
  longint exp_cycle, exp_retire, exp_stall;

  localparam logic [3:0] AOK = 4'b1000;
  localparam logic [3:0] HLT = 4'b0100;
  localparam logic [3:0] ADR = 4'b0010;
  localparam logic [3:0] INS = 4'b0001;

  // Control word order: F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall
  localparam logic [5:0] CTRL_FLUSH = 6'b101110;
  localparam logic [5:0] CTRL_HALT  = 6'b110111;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [5:0] ctrl_word();
    return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic benign_inputs();
    D_icode = 4'h2; E_icode = 4'h2; M_icode = 4'h2; W_icode = 4'h2;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_cnd = 1'b1;
    m_stat = AOK; W_stat = AOK;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reset for one edge, walk through FLUSH and IDLE, then start into RUN.
  // With poke_start, start is held high during FLUSH (must be ignored) and
  // one extra IDLE cycle is spent with start low.
  task automatic bringup(input bit poke_start);
    logic [1:0] e;
    rst = 1'b1; start = 1'b0; benign_inputs();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("bringup_state[%0d]", i), state, e);
      chk($sformatf("bringup_ctrl[%0d]", i), ctrl_word(), CTRL_FLUSH);
      start = poke_start && (i < 3);
      if (i < 4) tick();
    end
    chk("bringup_cycle_cnt", cycle_cnt, 0);
    chk("bringup_cpu_stat", cpu_stat, AOK);
    if (poke_start) begin
      tick();
      chk("idle_hold_state", state, 2'd1);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_entry_state", state, 2'd2);
    exp_cycle = 0; exp_retire = 0; exp_stall = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] d_ic, e_ic, m_ic, w_ic, srca, srcb, dstm;
    logic       cnd;
    logic [3:0] mst;
    logic [5:0] ctrl;  // expected F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall
  } vec_t;

  vec_t vec[11];

  initial begin
    //           D     E     M     W     srcA  srcB  dstM  cnd   m_stat expected
    vec[0]  = '{4'h2, 4'h2, 4'h2, 4'h2, 4'hF, 4'hF, 4'hF, 1'b1, AOK, 6'b000000}; // no hazard
    vec[1]  = '{4'h2, 4'h5, 4'h2, 4'h2, 4'h2, 4'hF, 4'h2, 1'b1, AOK, 6'b110100}; // mrmovl load-use srcA
    vec[2]  = '{4'h2, 4'hB, 4'h2, 4'h2, 4'hF, 4'h3, 4'h3, 1'b1, AOK, 6'b110100}; // popl load-use srcB
    vec[3]  = '{4'h2, 4'h5, 4'h2, 4'h2, 4'hF, 4'hF, 4'hF, 1'b1, AOK, 6'b000000}; // dstM none: no hazard
    vec[4]  = '{4'h9, 4'h7, 4'h2, 4'h2, 4'hF, 4'hF, 4'hF, 1'b0, AOK, 6'b101100}; // mispredict + ret
    vec[5]  = '{4'h2, 4'h2, 4'h9, 4'h2, 4'hF, 4'hF, 4'hF, 1'b1, AOK, 6'b101000}; // ret in M
    vec[6]  = '{4'h9, 4'h5, 4'h2, 4'h2, 4'h4, 4'hF, 4'h4, 1'b1, AOK, 6'b110100}; // load-use beats ret
    vec[7]  = '{4'h2, 4'h7, 4'h2, 4'h2, 4'hF, 4'hF, 4'hF, 1'b1, AOK, 6'b000000}; // jump taken
    vec[8]  = '{4'h2, 4'h2, 4'h2, 4'h2, 4'hF, 4'hF, 4'hF, 1'b1, HLT, 6'b000010}; // halt in memory
    vec[9]  = '{4'h2, 4'h2, 4'h2, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, INS, 6'b000010}; // nop in W, INS in M
    vec[10] = '{4'h2, 4'h5, 4'h2, 4'h1, 4'h6, 4'h6, 4'h6, 1'b0, AOK, 6'b110100}; // both srcs match
  end

  // ---------------- main test ----------------
  initial begin
    rst = 1'b0; start = 1'b0; benign_inputs();
    tick();

    // Bring-up with start poked during FLUSH.
    bringup(1'b1);

    // Table-driven RUN-state combinational checks with counter model.
    for (int i = 0; i < 11; i++) begin
      D_icode = vec[i].d_ic; E_icode = vec[i].e_ic; M_icode = vec[i].m_ic;
      W_icode = vec[i].w_ic; d_srcA = vec[i].srca; d_srcB = vec[i].srcb;
      E_dstM = vec[i].dstm; e_cnd = vec[i].cnd; m_stat = vec[i].mst; W_stat = AOK;
      #2;
      chk($sformatf("vec%0d_ctrl", i), ctrl_word(), vec[i].ctrl);
      exp_cycle++;
      if (vec[i].w_ic != 4'h1) exp_retire++;
      if (vec[i].ctrl[5] || vec[i].ctrl[3] || vec[i].ctrl[2]) exp_stall++;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_state", i), state, 2'd2);
      chk($sformatf("vec%0d_cycle_cnt", i), cycle_cnt, exp_cycle);
      chk($sformatf("vec%0d_retire_cnt", i), retire_cnt, exp_retire);
      chk($sformatf("vec%0d_stall_cnt", i), stall_cnt, exp_stall);
    end

    // Exception sequence: ADR in memory, then in write-back, combined with a load-use hazard.
    benign_inputs();
    m_stat = ADR;
    #2;
    chk("adr_m_ctrl", ctrl_word(), 6'b000010);
    tick();
    exp_cycle++; exp_retire++;
    chk("adr_m_state", state, 2'd2);
    m_stat = AOK; W_stat = ADR;
    E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;
    #2;
    chk("adr_w_ctrl", ctrl_word(), 6'b110111);
    chk("adr_w_cpu_stat_before", cpu_stat, AOK);
    tick();
    exp_cycle++; exp_stall++;
    chk("halt_state", state, 2'd3);
    chk("halt_cpu_stat", cpu_stat, ADR);
    chk("halt_ctrl", ctrl_word(), CTRL_HALT);
    chk("halt_cycle_cnt", cycle_cnt, exp_cycle);
    chk("halt_retire_cnt", retire_cnt, exp_retire);
    chk("halt_stall_cnt", stall_cnt, exp_stall);
    benign_inputs(); W_stat = INS; start = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    start = 1'b0; W_stat = AOK;
    tick();
    chk("halted_hold_state", state, 2'd3);
    chk("halted_hold_cpu_stat", cpu_stat, ADR);
    chk("halted_hold_ctrl", ctrl_word(), CTRL_HALT);
    chk("frozen_cycle_cnt", cycle_cnt, exp_cycle);
    chk("frozen_retire_cnt", retire_cnt, exp_retire);
    chk("frozen_stall_cnt", stall_cnt, exp_stall);

    // Saturation: 20 RUN cycles on both instances.
    bringup(1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat4_cycle_cnt", s_cycle_cnt, 4'hF);
    chk("sat4_retire_cnt", s_retire_cnt, 4'hF);
    chk("sat4_stall_cnt", s_stall_cnt, 4'h0);
    chk("wide_cycle_cnt", cycle_cnt, 20);
    for (int i = 0; i < 3; i++) tick();
    chk("sat4_cycle_hold", s_cycle_cnt, 4'hF);
    chk("wide_cycle_cnt_23", cycle_cnt, 23);

    // Mid-RUN reset with cycle_cnt=7; rst outranks start and a HLT status.
    bringup(1'b0);
    for (int i = 0; i < 7; i++) tick();
    chk("pre_rst_cycle_cnt", cycle_cnt, 7);
    rst = 1'b1; start = 1'b1; W_stat = HLT;
    tick();
    chk("rst_state", state, 2'd0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_retire_cnt", retire_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_cpu_stat", cpu_stat, AOK);
    chk("rst_ctrl", ctrl_word(), CTRL_FLUSH);
    rst = 1'b0; start = 1'b0; W_stat = AOK;
    tick();
    chk("post_rst_state", state, 2'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 4: number of cycles the pipeline is bubbled after reset.
REQ-002 SHALL have parameter CNT_W, default 32: width of each performance counter.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: pulse that begins execution from IDLE.
REQ-006 SHALL have ports D_icode, E_icode, M_icode, W_icode, inputs, 4 each: icode held in each pipeline register.
REQ-007 SHALL have ports d_srcA and d_srcB, inputs, 4 each: decode source register IDs; 4'hF means none.
REQ-008 SHALL have port E_dstM, input, 4: execute-stage load destination register.
REQ-009 SHALL have port e_cnd, input, 1: execute-stage condition result.
REQ-010 SHALL have ports m_stat and W_stat, inputs, 4 each: stat codes 4'b1000 AOK, 4'b0100 HLT, 4'b0010 ADR, 4'b0001 INS.
REQ-011 SHALL have ports F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, outputs, 1 each: stage controls.
REQ-012 SHALL have port state, output, 2: current state, encoded FLUSH=0, IDLE=1, RUN=2, HALTED=3.
REQ-013 SHALL have port cpu_stat, output, 4: latched final status.
REQ-014 SHALL have ports cycle_cnt, retire_cnt and stall_cnt, outputs, CNT_W each: performance counters.

Function
REQ-015 SHALL implement the FSM FLUSH -> IDLE after FLUSH_CYCLES cycles; IDLE -> RUN on the cycle after start=1; RUN -> HALTED on the edge where W_stat != 4'b1000; HALTED held until rst.
REQ-016 SHALL ignore start in every state other than IDLE.
REQ-017 SHALL, in FLUSH and IDLE, drive F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1, D_stall=0, W_stall=0.
REQ-018 SHALL, in HALTED, drive F_stall=1, D_stall=1, E_bubble=1, M_bubble=1, W_stall=1, D_bubble=0.
REQ-019 SHALL, in RUN, compute outputs combinationally from the current inputs per REQ-020 to REQ-027.
REQ-020 SHALL define loaduse = (E_icode==5 or E_icode==4'hB) and E_dstM!=4'hF and (E_dstM==d_srcA or E_dstM==d_srcB).
REQ-021 SHALL define retp = 9 present in D_icode, E_icode or M_icode.
REQ-022 SHALL define mispred = (E_icode==7 and e_cnd==0).
REQ-023 SHALL drive F_stall = loaduse or retp, and D_stall = loaduse.
REQ-024 SHALL drive D_bubble = mispred or (retp and not loaduse).
REQ-025 SHALL drive E_bubble = mispred or loaduse.
REQ-026 SHALL drive M_bubble = 1 when m_stat or W_stat is HLT, ADR or INS.
REQ-027 SHALL drive W_stall = (W_stat != AOK).
REQ-028 SHALL latch W_stat into cpu_stat on RUN -> HALTED; cpu_stat SHALL not change otherwise.
REQ-029 SHALL increment cycle_cnt on every cycle spent in RUN.
REQ-030 SHALL increment retire_cnt in RUN when W_stat==AOK and W_icode!=1.
REQ-031 SHALL increment stall_cnt in RUN when F_stall, D_bubble or E_bubble is 1.
REQ-032 SHALL make all counters saturate at all-ones, with no wrap.
REQ-033 SHALL count no cycle in FLUSH, IDLE or HALTED.
REQ-034 SHALL, when an exception and a hazard are both present in RUN, apply REQ-023 to REQ-027 independently, with the FSM transition taking effect next cycle.

Reset
REQ-035 SHALL, on rst=1 at a clock edge, in any state including mid-RUN, set state=FLUSH, reset the flush counter, set all counters to 0 and set cpu_stat=4'b1000.
REQ-036 SHALL give rst priority over start and over any stat input.

Verification
REQ-037 SHALL be checked by: rst 1 cycle then start at cycle 6 -> state 0 for 4 cycles, then 1, then 2; outputs per REQ-017 until RUN.
REQ-038 SHALL be checked by: RUN, E_icode=5, E_dstM=2, d_srcA=2 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt +1.
REQ-039 SHALL be checked by: RUN, E_icode=7, e_cnd=0, D_icode=9 -> D_bubble=1, E_bubble=1, F_stall=1, D_stall=0.
REQ-040 SHALL be checked by: RUN, m_stat=4'b0010, then W_stat=4'b0010 -> M_bubble=1 both cycles, W_stall=1, next state=3, cpu_stat=4'b0010, counters frozen.
REQ-041 SHALL be checked by: CNT_W=4, 20 RUN cycles -> cycle_cnt=4'hF, held.
REQ-042 SHALL be checked by: rst asserted mid-RUN with cycle_cnt=7 -> next cycle state=0, cycle_cnt=0, cpu_stat=4'b1000.
